// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, instruction size and fetch-unit FSM states.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that beats push/pop.
module sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: credit-limited sequential requests, in-order
// response buffering with PC tagging, and redirect flush with stale-response draining.
module instr_fetch_unit #(
    parameter int unsigned      XLEN     = riscv_pkg::XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] PC_o,
    input  logic            ins_ready
);

    import riscv_pkg::ifu_state_t;
    import riscv_pkg::BOOT;
    import riscv_pkg::RUN;
    import riscv_pkg::DRAIN;
    import riscv_pkg::INSTR_BYTES;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    ifu_state_t          state;
    logic [XLEN-1:0]     fetch_pc;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    out_next;

    logic                accept;
    logic                rsp_dec;
    logic                rsp_live;
    logic                push_ins;
    logic [SUM_W-1:0]    credit_used;

    logic [2*XLEN-1:0]   fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic [XLEN-1:0]     pcq_head;
    logic                pcq_full;
    logic                pcq_empty;
    logic [CNT_W-1:0]    pcq_count_unused;
    logic [1:0]          redirect_pc_unused;

    assign redirect_pc_unused = redirect_pc[1:0];

    // Buffered plus in-flight fetches never exceed DEPTH, so pushes cannot overflow.
    assign credit_used    = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign imem_req_valid = (state == RUN) & ~redirect_valid & (credit_used < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign rsp_dec  = imem_rsp_valid & (outstanding != '0);
    assign rsp_live = imem_rsp_valid & (state == RUN) & ~redirect_valid;
    assign push_ins = rsp_live & ~pcq_empty & ~fifo_full;

    assign ins_valid = ~fifo_empty;
    assign PC_o      = fifo_rdata[2*XLEN-1:XLEN];
    assign ins       = fifo_rdata[XLEN-1:0];

    always_comb begin
        out_next = outstanding;
        case ({accept, rsp_dec})
            2'b10:   out_next = outstanding + CNT_W'(1);
            2'b01:   out_next = outstanding - CNT_W'(1);
            default: out_next = outstanding;
        endcase
    end

    // Fetch FSM, fetch PC and in-flight counter; redirect wins over sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect_valid && (out_next != '0)) state <= DRAIN;
                DRAIN:   if (!redirect_valid && (out_next == '0)) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_ins_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (push_ins),
        .pop   (ins_valid & ins_ready),
        .wdata ({pcq_head, imem_rsp_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Addresses of accepted requests, retired in order as responses return.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (accept & ~pcq_full),
        .pop   (rsp_live),
        .wdata (fetch_pc),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count_unused)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, backpressure, redirects, wrap-around, async reset.
module tb_instr_fetch_unit;

    localparam int MEM_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] PC_o;
    logic        ins_ready = 1'b0;

    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_req_ready = 1'b1;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_ins_valid;
    logic [31:0] w_ins;
    logic [31:0] w_pc;
    logic        w_ins_ready = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int first_iv = -1;
    int r_cyc;
    logic hold = 1'b0;

    logic [31:0] mq_a[$];
    int          mq_due[$];
    logic [31:0] acc_a[$];
    int          acc_c[$];
    int          rsp_c[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] w_acc[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ins_valid(ins_valid), .ins(ins), .PC_o(PC_o), .ins_ready(ins_ready)
    );

    instr_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(w_req_ready),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .ins_valid(w_ins_valid), .ins(w_ins), .PC_o(w_pc), .ins_ready(w_ins_ready)
    );

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_a.size()) ? acc_a[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int accc_at(input int i);
        return (i < acc_c.size()) ? acc_c[i] : -1;
    endfunction

    function automatic int rspc_at(input int i);
        return (i < rsp_c.size()) ? rsp_c[i] : -100;
    endfunction

    function automatic logic [31:0] poppc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] popins_at(input int i);
        return (i < pop_ins.size()) ? pop_ins[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wacc_at(input int i);
        return (i < w_acc.size()) ? w_acc[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the memory model: present a due response, sample at negedge, log at posedge.
    task automatic tick();
        logic s_acc, s_rsp, s_pop, s_wacc;
        logic [31:0] s_addr, s_pc, s_ins, s_waddr;
        if (!hold && mq_a.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rdat(mq_a[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
        s_acc   = imem_req_valid & imem_req_ready;
        s_addr  = imem_req_addr;
        s_rsp   = imem_rsp_valid;
        s_pop   = ins_valid & ins_ready;
        s_pc    = PC_o;
        s_ins   = ins;
        s_wacc  = w_req_valid & w_req_ready;
        s_waddr = w_req_addr;
        if (ins_valid && first_iv < 0) first_iv = cyc;
        @(posedge clk);
        #1;
        if (s_rsp) begin
            rsp_c.push_back(cyc);
            void'(mq_a.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_acc) begin
            mq_a.push_back(s_addr);
            mq_due.push_back(cyc + MEM_LAT);
            acc_a.push_back(s_addr);
            acc_c.push_back(cyc);
        end
        if (s_pop) begin
            pop_pc.push_back(s_pc);
            pop_ins.push_back(s_ins);
        end
        if (s_wacc) w_acc.push_back(s_waddr);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq_a.delete(); mq_due.delete();
        acc_a.delete(); acc_c.delete(); rsp_c.delete();
        pop_pc.delete(); pop_ins.delete(); w_acc.delete();
        first_iv = -1;
        #1;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Boot sequence, reset values, latency and streaming throughput
        #1;
        imem_req_ready = 1'b1; ins_ready = 1'b1; hold = 1'b0;
        assert_reset();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0100);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_pc_o", PC_o, 32'd0);
        check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
        release_reset();
        check("boot_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check("run_req_valid", 32'(imem_req_valid), 32'd1);
        ticks(9);
        check("boot_addr0", acc_at(0), 32'h0000_0100);
        check("boot_addr1", acc_at(1), 32'h0000_0104);
        check("boot_addr2", acc_at(2), 32'h0000_0108);
        check("boot_iv_latency", 32'(first_iv - accc_at(0)), 32'd2);
        check("boot_pop_pc0", poppc_at(0), 32'h0000_0100);
        check("boot_pop_ins0", popins_at(0), rdat(32'h0000_0100));
        check("boot_pop_pc3", poppc_at(3), 32'h0000_010C);
        check("boot_throughput", 32'(accc_at(5) - accc_at(1)), 32'd4);
        check("wrap_addr0", wacc_at(0), 32'hFFFF_FFF8);
        check("wrap_addr1", wacc_at(1), 32'hFFFF_FFFC);
        check("wrap_addr2", wacc_at(2), 32'h0000_0000);
        check("wrap_addr3", wacc_at(3), 32'h0000_0004);

        // Backpressure: credit cap of 4, stable head, in-order drain and resume
        assert_reset();
        imem_req_ready = 1'b1; ins_ready = 1'b0; hold = 1'b0;
        release_reset();
        ticks(11);
        check("bp_accepts", 32'(acc_a.size()), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_ins_valid", 32'(ins_valid), 32'd1);
        check("bp_head_pc", PC_o, 32'h0000_0100);
        check("bp_head_ins", ins, rdat(32'h0000_0100));
        ins_ready = 1'b1;
        ticks(10);
        check("bp_pop0", poppc_at(0), 32'h0000_0100);
        check("bp_pop1", poppc_at(1), 32'h0000_0104);
        check("bp_pop3", poppc_at(3), 32'h0000_010C);
        check("bp_pop3_ins", popins_at(3), rdat(32'h0000_010C));
        check("bp_resume", acc_at(4), 32'h0000_0110);

        // Redirect with two in flight: drain stale responses first
        assert_reset();
        imem_req_ready = 1'b0; ins_ready = 1'b1; hold = 1'b1;
        release_reset();
        tick();
        imem_req_ready = 1'b1;
        ticks(2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        check("rd2_ins_valid", 32'(ins_valid), 32'd0);
        ticks(2);
        check("rd2_no_early_req", 32'(acc_a.size()), 32'd2);
        hold = 1'b0;
        ticks(8);
        check("rd2_new_addr", acc_at(2), 32'h0000_2000);
        check("rd2_after_stale", 32'(accc_at(2) - rspc_at(1)), 32'd1);
        check("rd2_first_pop_pc", poppc_at(0), 32'h0000_2000);
        check("rd2_first_pop_ins", popins_at(0), rdat(32'h0000_2000));

        // Redirect coinciding with the only outstanding response
        assert_reset();
        imem_req_ready = 1'b0; ins_ready = 1'b1; hold = 1'b1;
        release_reset();
        tick();
        imem_req_ready = 1'b1;
        tick();
        hold = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        r_cyc = cyc;
        tick();
        redirect_valid = 1'b0;
        ticks(5);
        check("rd1_new_addr", acc_at(1), 32'h0000_2000);
        check("rd1_next_cycle", 32'(accc_at(1) - r_cyc), 32'd1);
        check("rd1_first_pop", poppc_at(0), 32'h0000_2000);

        // Back-to-back redirects while draining: last target wins
        assert_reset();
        imem_req_ready = 1'b0; ins_ready = 1'b1; hold = 1'b1;
        release_reset();
        tick();
        imem_req_ready = 1'b1;
        ticks(2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect_pc = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        tick();
        check("b2b_no_early_req", 32'(acc_a.size()), 32'd2);
        hold = 1'b0;
        ticks(8);
        check("b2b_new_addr", acc_at(2), 32'h0000_0400);
        check("b2b_first_pop", poppc_at(0), 32'h0000_0400);

        // Redirect with a non-empty buffer and nothing in flight
        assert_reset();
        imem_req_ready = 1'b0; ins_ready = 1'b0; hold = 1'b0;
        release_reset();
        tick();
        imem_req_ready = 1'b1;
        ticks(2);
        imem_req_ready = 1'b0;
        ticks(3);
        check("flush_pre_valid", 32'(ins_valid), 32'd1);
        check("flush_pre_pc", PC_o, 32'h0000_0100);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0503; imem_req_ready = 1'b1;
        r_cyc = cyc;
        tick();
        redirect_valid = 1'b0;
        check("flush_ins_valid", 32'(ins_valid), 32'd0);
        tick();
        check("flush_new_addr", acc_at(2), 32'h0000_0500);
        check("flush_next_cycle", 32'(accc_at(2) - r_cyc), 32'd1);

        // Asynchronous reset mid-burst with three buffered entries
        assert_reset();
        imem_req_ready = 1'b0; ins_ready = 1'b0; hold = 1'b0;
        release_reset();
        tick();
        imem_req_ready = 1'b1;
        ticks(3);
        imem_req_ready = 1'b0;
        tick();
        check("ar_pre_ins_valid", 32'(ins_valid), 32'd1);
        check("ar_pre_req_valid", 32'(imem_req_valid), 32'd1);
        check("ar_pre_head", PC_o, 32'h0000_0100);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ins_valid", 32'(ins_valid), 32'd0);
        check("ar_req_valid", 32'(imem_req_valid), 32'd0);
        check("ar_req_addr", imem_req_addr, 32'h0000_0100);
        check("ar_ins", ins, 32'd0);
        release_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
